alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request channel and a
// valid/ready response channel.  Single-cycle ops (ADD, SUB, AND, OR, SLT,
// SLL, SRA) produce their response in the cycle after acceptance; MUL is an
// iterative shift-add producing the low WIDTH bits of the product.
//
// Configuration macro: ALU_SEQ_MUL_EN
//   defined   -> op 111 runs the iterative multiplier (WIDTH-cycle latency)
//   undefined -> no multiplier hardware; op 111 completes in one cycle with
//                y = 0, z = 1, err = 1
//
// Ports
//   clk        clock, all state changes on rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid
//   in_ready   request ready (IDLE, or DONE while out_ready is high)
//   op[2:0]    operation select
//   a, b       operands (WIDTH bits)
//   out_valid  response valid (high exactly in DONE)
//   out_ready  response ready
//   y          result (WIDTH bits)
//   z, ng      zero / negative flags of y
//   of, c      overflow / carry flags
//   err        unsupported-op flag
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             ng,
    output logic             of,
    output logic             c,
    output logic             err
);

    localparam int SH = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] MUL  = 2'd1;
`endif
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]       state;
    logic             accept;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_of;
    logic             r_err;

    // A new request may be taken in the same cycle the current response is
    // consumed, so in_ready in DONE follows out_ready combinationally.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // Single-cycle result path, evaluated on the live request inputs.
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        r_y     = '0;
        r_c     = 1'b0;
        r_of    = 1'b0;
        r_err   = 1'b0;
        case (op)
            OP_ADD: begin
                r_y  = add_sum[WIDTH-1:0];
                r_c  = add_sum[WIDTH];
                r_of = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r_y  = sub_sum[WIDTH-1:0];
                r_c  = sub_sum[WIDTH];
                r_of = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r_y = a & b;
            OP_OR:  r_y = a | b;
            OP_SLT: r_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: r_y = a << b[SH-1:0];
            OP_SRA: r_y = $signed(a) >>> b[SH-1:0];
            OP_MUL: begin
`ifndef ALU_SEQ_MUL_EN
                r_err = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SH-1:0] CNT_ONE = {{(SH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SH-1:0]      cnt;

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            y     <= '0;
            z     <= 1'b0;
            ng    <= 1'b0;
            of    <= 1'b0;
            c     <= 1'b0;
            err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                if (op == OP_MUL) begin
                    // Multiplier bit 0 is folded into the accept cycle so the
                    // remaining WIDTH-1 bits finish exactly WIDTH edges later.
                    state  <= MUL;
                    acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                    mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                    mplier <= {1'b0, b[WIDTH-1:1]};
                    cnt    <= CNT_ONE;
                end else
`endif
                begin
                    state <= DONE;
                    y     <= r_y;
                    z     <= (r_y == '0);
                    ng    <= r_y[WIDTH-1];
                    of    <= r_of;
                    c     <= r_c;
                    err   <= r_err;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_ONE;
                if (cnt == '1) begin
                    state <= DONE;
                    y     <= acc_next[WIDTH-1:0];
                    z     <= (acc_next[WIDTH-1:0] == '0);
                    ng    <= acc_next[WIDTH-1];
                    of    <= |acc_next[2*WIDTH-1:WIDTH];
                    c     <= 1'b0;
                    err   <= 1'b0;
                end
            end
`endif
            else if ((state == DONE) && out_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH = 32) using a scoreboard queue:
// expected responses are pushed when a request is accepted and popped when
// the DUT hands over a response.  Honours ALU_SEQ_MUL_EN like the design.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] y;
        logic        z;
        logic        ng;
        logic        of;
        logic        c;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic        z, ng, of, c, err;

    int vectors    = 0;
    int miscompares = 0;
    exp_t sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .z         (z),
        .ng        (ng),
        .of        (of),
        .c         (c),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model built from wide integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] w);
        exp_t            e;
        longint          sx;
        longint          sw;
        longint          r;
        longint unsigned s;
        longint unsigned p;
        logic [4:0]      sh;
        logic [31:0]     ones;
        sx   = longint'($signed(x));
        sw   = longint'($signed(w));
        sh   = w[4:0];
        ones = 32'hFFFF_FFFF;
        e    = '0;
        case (o)
            3'd0: begin
                s    = longint'(x) + longint'(w);
                e.y  = s[31:0];
                e.c  = s[32];
                r    = sx + sw;
                e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd1: begin
                e.y  = x - w;
                e.c  = (x >= w);
                r    = sx - sw;
                e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: e.y = x & w;
            3'd3: e.y = x | w;
            3'd4: e.y = (sx < sw) ? 32'd1 : 32'd0;
            3'd5: e.y = x << sh;
            3'd6: e.y = (x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0);
            3'd7: begin
`ifdef ALU_SEQ_MUL_EN
                p    = longint'(x) * longint'(w);
                e.y  = p[31:0];
                e.of = (p[63:32] != 32'd0);
`else
                e.y   = 32'd0;
                e.err = 1'b1;
`endif
            end
        endcase
        e.z  = (e.y == 32'd0);
        e.ng = e.y[31];
        return e;
    endfunction

    // Response monitor: a handshake seen at the falling edge completes at
    // the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_response got y=%h flags(z,ng,of,c,err)=%b%b%b%b%b, none expected",
                         y, z, ng, of, c, err);
            end else begin
                e = sb.pop_front();
                if ({y, z, ng, of, c, err} !== e) begin
                    miscompares++;
                    $display("FAIL response got y=%h flags(z,ng,of,c,err)=%b%b%b%b%b exp y=%h flags=%b%b%b%b%b",
                             y, z, ng, of, c, err, e.y, e.z, e.ng, e.of, e.c, e.err);
                end
            end
        end
    end

    // Present one request (called just after a rising edge) and hold it until
    // accepted; returns just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] w);
        bit got;
        got      = 1'b0;
        op       = o;
        a        = x;
        b        = w;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back(model(o, x, w));
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout op=%0d got in_ready=0 for 200 cycles, required 1", o);
        end
    endtask

    // Wait (bounded) for every expected response to be consumed.
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd0;
        a         = 32'h1;
        b         = 32'h1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || y !== 32'd0 || {z, ng, of, c, err} !== 5'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got out_valid=%b y=%h flags=%b%b%b%b%b in_ready=%b, required 0/0/00000/1",
                     out_valid, y, z, ng, of, c, err, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle;
        logic [2:0]  t_op [12];
        logic [31:0] t_a  [12];
        logic [31:0] t_b  [12];
        bit ok;
        t_op = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd5, 3'd6,
                 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        t_a  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'h3, 32'hF0F0_1234, 32'h0F0F_0000, 32'h7FFF_FFFF, 32'h7000_0000};
        t_b  = '{32'h1, 32'h1, 32'h5, 32'h1, 32'h3F, 32'h4,
                 32'h1, 32'h7, 32'h0FF0_FFFF, 32'h0000_00F0, 32'h8000_0000, 32'h21};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL latency_1 op=%0d got out_valid=%b one cycle after accept, required 1",
                         t_op[i], out_valid);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 8; i++) begin
            send(3'($urandom_range(0, 6)), $urandom, $urandom);
            @(posedge clk); #1;
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_drain got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_mul;
        bit ok;
`ifdef ALU_SEQ_MUL_EN
        out_ready = 1'b0;
        send(3'd7, 32'h0001_0000, 32'h0001_0000);
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_busy cycle %0d got in_ready=%b out_valid=%b, required 0/0",
                         k, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_latency got out_valid=%b in_ready=%b at cycle 32, required 1/0",
                     out_valid, in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send(3'd7, 32'h0000_1234, 32'h0000_5678);
        send(3'd7, $urandom, $urandom);
`else
        out_ready = 1'b1;
        send(3'd7, 32'h0001_0000, 32'h0001_0000);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_disabled_latency got out_valid=%b, required 1", out_valid);
        end
        @(posedge clk); #1;
`endif
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mul_drain got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_hold;
        exp_t        e;
        logic [31:0] x, w;
        bit ok;
        x = $urandom;
        w = $urandom;
        e = model(3'd0, x, w);
        out_ready = 1'b0;
        send(3'd0, x, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {y, z, ng, of, c, err} !== e) begin
                miscompares++;
                $display("FAIL hold_stable cycle %0d got out_valid=%b in_ready=%b y=%h exp 1/0 y=%h",
                         k, out_valid, in_ready, y, e.y);
            end
            @(posedge clk); #1;
        end
        x = $urandom;
        w = $urandom;
        out_ready = 1'b1;
        op        = 3'd1;
        a         = x;
        b         = w;
        in_valid  = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release_accept got in_ready=%b, required 1", in_ready);
        end else begin
            sb.push_back(model(3'd1, x, w));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL done_to_done got out_valid=%b, required 1", out_valid);
        end
        @(posedge clk); #1;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_drain got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit got;
        logic [2:0]  o;
        logic [31:0] x, w;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            o        = (n == 7) ? 3'd7 : 3'($urandom_range(0, 6));
            x        = $urandom;
            w        = (n % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            op       = o;
            a        = x;
            b        = w;
            in_valid = 1'b1;
            got      = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin
                    sb.push_back(model(o, x, w));
                    got = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            if (!got) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_accept_timeout req %0d got in_ready=0, required 1", n);
            end
        end
        in_valid = 1'b0;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_drain got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_abort;
        bit seen;
        bit ok;
`ifdef ALU_SEQ_MUL_EN
        out_ready = 1'b1;
        send(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin
            @(posedge clk); #1;
        end
`else
        out_ready = 1'b0;
        send(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) begin
            @(posedge clk); #1;
        end
`endif
        reset     = 1'b1;
        out_ready = 1'b1;
        op        = 3'd0;
        a         = 32'h11;
        b         = 32'h22;
        in_valid  = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort got out_valid=%b in_ready=%b y=%h, required 0/1/00000000",
                     out_valid, in_ready, y);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL stale_response got out_valid=1 after abort, required 0");
        end
        send(3'd3, 32'hA5A5_0000, 32'h0000_5A5A);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL recover_drain got %0d outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
